// File: rtl/jtag_readback_if.sv
// Memory read port between jtag_readback and its backing memory.
// Latency: data_i must be valid exactly one clk_i cycle after re_o.
// Backpressure: none; the memory must return data every time re_o pulses.
// Ports (master = jtag_readback side):
//   re_o        read enable, one-cycle pulse
//   read_addr_o read address, valid while re_o=1
//   data_i      read data returned by the memory
interface jtag_readback_if #(
  parameter int BIT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10
) ();
  logic                  re_o;
  logic [ADDR_WIDTH-1:0] read_addr_o;
  logic [BIT_WIDTH-1:0]  data_i;

  modport master (output re_o, output read_addr_o, input data_i);
  modport slave  (input re_o, input read_addr_o, output data_i);
endinterface

// File: rtl/jtag_readback.sv
// Streams memory words out through a BSCANE2 USER chain, LSB first, with a one-word prefetch.
// Latency: a TCK edge is acted on 3 clk_i cycles after it occurs; tdo_o follows 1 cycle later.
// Backpressure: none; a word needed before its prefetch lands is sent as zeros and flagged.
// Ports:
//   clk_i, rst_i                        system clock, synchronous active-high reset
//   tck_i, sel_i, capture_i, shift_i    raw BSCANE2 controls (asynchronous to clk_i)
//   mem                                 memory read port (re_o / read_addr_o / data_i)
//   tdo_o                               registered serial data to BSCANE2 TDO
//   underrun_o                          sticky: a word was consumed with no valid prefetch
module jtag_readback #(
  parameter int BIT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            tck_i,
  input  logic            sel_i,
  input  logic            capture_i,
  input  logic            shift_i,
  jtag_readback_if.master mem,
  output logic            tdo_o,
  output logic            underrun_o
);

  localparam int CNT_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIT_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_READY} state_t;

  state_t r_state;
  state_t w_state_nxt;

  (* ASYNC_REG = "TRUE" *) logic [1:0] r_tck_sync;
  (* ASYNC_REG = "TRUE" *) logic [1:0] r_sel_sync;
  (* ASYNC_REG = "TRUE" *) logic [1:0] r_cap_sync;
  (* ASYNC_REG = "TRUE" *) logic [1:0] r_shf_sync;
  logic                  r_tck_d;
  logic                  r_sel_d;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BIT_WIDTH-1:0]  r_pf;
  logic                  r_pf_vld;
  logic [BIT_WIDTH-1:0]  r_shreg;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_tdo;
  logic                  r_underrun;

  logic                  w_sel;
  logic                  w_sel_rise;
  logic                  w_tck_rise;
  logic                  w_cap_ev;
  logic                  w_shf_ev;
  logic                  w_consume;
  logic                  w_latch;
  logic                  w_underrun_set;
  logic                  w_re;
  logic [BIT_WIDTH-1:0]  w_load_dat;

  assign w_sel      = r_sel_sync[1];
  assign w_sel_rise = w_sel & ~r_sel_d;
  assign w_tck_rise = r_tck_sync[1] & ~r_tck_d;
  // Capture wins if both controls are seen high on the same TCK edge.
  assign w_cap_ev   = w_tck_rise & w_sel & r_cap_sync[1];
  assign w_shf_ev   = w_tck_rise & w_sel & r_shf_sync[1] & ~r_cap_sync[1];
  assign w_consume  = w_cap_ev | (w_shf_ev & (r_bit_cnt == LAST_BIT));
  assign w_latch    = w_sel & (r_state == S_WAIT);
  // A consume coinciding with the prefetch latch takes the memory data directly.
  assign w_load_dat = w_latch  ? mem.data_i :
                      r_pf_vld ? r_pf       : '0;
  assign w_underrun_set = w_consume & ~w_latch & ~r_pf_vld;

  always_comb begin
    w_state_nxt = r_state;
    w_re        = 1'b0;
    case (r_state)
      S_IDLE:  if (w_sel) w_state_nxt = S_FETCH;
      S_FETCH: begin
        w_re        = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT:  w_state_nxt = w_consume ? S_FETCH : S_READY;
      S_READY: if (w_consume) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
    // Losing sel abandons whatever was in progress, including a fetch in flight.
    if (!w_sel) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tck_sync <= '0;
      r_sel_sync <= '0;
      r_cap_sync <= '0;
      r_shf_sync <= '0;
      r_tck_d    <= 1'b0;
      r_sel_d    <= 1'b0;
      r_addr     <= '0;
      r_pf       <= '0;
      r_pf_vld   <= 1'b0;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_tdo      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_tck_sync <= {r_tck_sync[0], tck_i};
      r_sel_sync <= {r_sel_sync[0], sel_i};
      r_cap_sync <= {r_cap_sync[0], capture_i};
      r_shf_sync <= {r_shf_sync[0], shift_i};
      r_tck_d    <= r_tck_sync[1];
      r_sel_d    <= w_sel;
      r_tdo      <= r_shreg[0];

      // Set is ordered after clear so an underrun on the sel-rise cycle is kept.
      if (w_sel_rise)     r_underrun <= 1'b0;
      if (w_underrun_set) r_underrun <= 1'b1;

      if (!w_sel) begin
        r_addr    <= '0;
        r_pf_vld  <= 1'b0;
        r_bit_cnt <= '0;
        r_shreg   <= '0;
      end else begin
        if (w_latch) begin
          r_pf   <= mem.data_i;
          r_addr <= r_addr + 1'b1;
        end

        if (w_consume)    r_pf_vld <= 1'b0;
        else if (w_latch) r_pf_vld <= 1'b1;

        if (w_consume)     r_shreg <= w_load_dat;
        else if (w_shf_ev) r_shreg <= r_shreg >> 1;

        if (w_cap_ev)      r_bit_cnt <= '0;
        else if (w_shf_ev) r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
      end
    end
  end

  assign mem.re_o        = w_re;
  assign mem.read_addr_o = r_addr;
  assign tdo_o           = r_tdo;
  assign underrun_o      = r_underrun;

endmodule
